// File: rtl/alu_uart_interface.sv
// Sequencer between the UART FIFOs and the ALU: pops A, B, opcode from RX, pushes the result to TX.
// Optional inter-byte frame timeout is compiled in with `define INTF_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int size    = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            rx_empty_i,
  input  logic [size-1:0] rx_data_i,
  output logic            rd_uart_o,
  input  logic            tx_full_i,
  output logic [size-1:0] tx_data_o,
  output logic            wr_uart_o,
  output logic [size-1:0] alu_a_o,
  output logic [size-1:0] alu_b_o,
  output logic [5:0]      alu_op_o,
  input  logic [size-1:0] alu_result_i,
  output logic            busy_o,
  output logic            frame_err_o
);
  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;

  state_t          state_q, state_d;
  logic [size-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [5:0]      op_q, op_d;
  logic            rd, wr, tmo;

`ifdef INTF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Zero unless waiting mid-frame on an empty RX, so every pop or state change restarts the wait.
  always_comb begin
    cnt_d = '0;
    tmo   = 1'b0;
    if ((state_q == GET_B || state_q == GET_OP) && rx_empty_i) begin
      if (cnt_q == CW'(TIMEOUT - 1)) tmo = 1'b1;
      else                           cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    rd      = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      GET_A:
        if (!rx_empty_i) begin
          rd = 1'b1; a_d = rx_data_i; state_d = GET_B;
        end
      GET_B:
        if (!rx_empty_i) begin
          rd = 1'b1; b_d = rx_data_i; state_d = GET_OP;
        end else if (tmo) state_d = GET_A;
      GET_OP:
        if (!rx_empty_i) begin
          rd = 1'b1; op_d = rx_data_i[5:0]; state_d = EXEC;
        end else if (tmo) state_d = GET_A;
      EXEC: begin
        res_d   = alu_result_i;
        state_d = SEND;
      end
      SEND:
        if (!tx_full_i) begin
          wr = 1'b1; state_d = GET_A;
        end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // A pop during reset would lose the byte; a pending push still goes out.
  assign rd_uart_o   = rd & ~reset_i;
  assign wr_uart_o   = wr;
  assign frame_err_o = tmo & ~reset_i;
  assign tx_data_o   = res_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_op_o    = op_q;
  assign busy_o      = (state_q != GET_A);
endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: queue-based RX/TX FIFO model, behavioural ALU, result scoreboard.
module tb_alu_uart_interface;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rx_empty, rd_uart, tx_full, wr_uart, busy, frame_err;
  logic [7:0] rx_data, tx_data, alu_a, alu_b, alu_result;
  logic [5:0] alu_op;

  int checks = 0, errors = 0;
  logic [7:0] rx_q[$], exp_q[$], txlog[$];
  int wr_cycs[$];
  bit rst_req = 1'b1, force_full = 1'b0, rand_bp = 1'b0, rand_gap = 1'b0;
  int cyc = 0, pops = 0, pushes = 0, pos = 0, a_pop_cyc = -1, op_pop_cyc = -1;
  int fe_cnt = 0, fe_cyc = -1;
  logic       rd_s, wr_s, busy_s, fe_s;
  logic [7:0] tx_s, a_s, b_s;
  logic [5:0] op_s;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'hFF;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  alu_uart_interface #(.size(8), .TIMEOUT(16)) dut (
    .clk_i(clk), .reset_i(reset), .rx_empty_i(rx_empty), .rx_data_i(rx_data),
    .rd_uart_o(rd_uart), .tx_full_i(tx_full), .tx_data_o(tx_data), .wr_uart_o(wr_uart),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_result_i(alu_result),
    .busy_o(busy), .frame_err_o(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample just after, update FIFO models, wait for posedge.
  task automatic cycle();
    bit rx_ok;
    @(negedge clk);
    reset    = rst_req;
    rx_ok    = !rand_gap || ($urandom_range(0, 3) != 0);
    rx_empty = !(rx_ok && rx_q.size() > 0);
    rx_data  = rx_empty ? 8'($urandom) : rx_q[0];
    tx_full  = force_full || (rand_bp && $urandom_range(0, 2) == 0);
    #1;
    rd_s = rd_uart; wr_s = wr_uart; busy_s = busy; fe_s = frame_err;
    tx_s = tx_data; a_s = alu_a; b_s = alu_b; op_s = alu_op;
    chk("rd_on_empty", 32'(rd_s & rx_empty), 32'd0);
    if (rd_s && rx_q.size() > 0) begin
      if (pos == 0) a_pop_cyc = cyc;
      if (pos == 2) op_pop_cyc = cyc;
      pos = (pos + 1) % 3;
      void'(rx_q.pop_front());
      pops++;
    end
    if (wr_s) begin
      chk("wr_on_full", 32'(tx_full), 32'd0);
      txlog.push_back(tx_s);
      wr_cycs.push_back(cyc);
      pushes++;
    end
    if (fe_s) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    rx_q.push_back(a); rx_q.push_back(b); rx_q.push_back(op);
    exp_q.push_back(alu_f(a, b, op[5:0]));
  endtask

  task automatic wait_pops(input string tag, input int target);
    int n = 0;
    while (pops < target && n < 300) begin cycle(); n++; end
    chk({tag, "_pops"}, 32'(pops), 32'(target));
  endtask

  task automatic wait_push(input string tag);
    int p0 = pushes;
    int n  = 0;
    while (pushes == p0 && n < 300) begin cycle(); n++; end
    chk({tag, "_push_seen"}, 32'(pushes > p0), 32'd1);
    if (pushes > p0 && txlog.size() <= exp_q.size())
      chk({tag, "_model"}, 32'(txlog[txlog.size()-1]), 32'(exp_q[txlog.size()-1]));
  endtask

  initial begin
    int p, q;
    logic [5:0] ops[7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h3F};
    logic [7:0] ob;
    reset = 1'b1; rx_empty = 1'b1; rx_data = '0; tx_full = 1'b0;

    // Reset state
    cycle(); cycle();
    rst_req = 1'b0;
    cycle();
    chk("rst_rd", 32'(rd_s), 32'd0);
    chk("rst_wr", 32'(wr_s), 32'd0);
    chk("rst_busy", 32'(busy_s), 32'd0);
    chk("rst_ferr", 32'(fe_s), 32'd0);
    chk("rst_tx", 32'(tx_s), 32'd0);
    chk("rst_ab", 32'({a_s, b_s}), 32'd0);
    chk("rst_op", 32'(op_s), 32'd0);

    // Add, with minimum latency
    frame(8'h05, 8'h03, 8'h20);
    wait_push("t1");
    chk("t1_tx", 32'(txlog[txlog.size()-1]), 32'h08);
    chk("t1_latency", 32'(wr_cycs[wr_cycs.size()-1] - op_pop_cyc), 32'd2);
    cycle();
    chk("t1_busy_idle", 32'(busy_s), 32'd0);
    chk("t1_op", 32'(op_s), 32'h20);
    chk("t1_ab", 32'({a_s, b_s}), 32'h0503);

    // Opcode upper bits ignored
    frame(8'h03, 8'h05, 8'hE2);
    wait_push("t2");
    chk("t2_tx", 32'(txlog[txlog.size()-1]), 32'hFE);
    cycle();
    chk("t2_op", 32'(op_s), 32'h22);

    // Undefined opcode
    frame(8'h0F, 8'h01, 8'h3F);
    wait_push("t3");
    chk("t3_tx", 32'(txlog[txlog.size()-1]), 32'hFF);

    // TX backpressure for 10 cycles
    force_full = 1'b1;
    p = pushes;
    frame(8'hAA, 8'h55, 8'h26);
    wait_pops("t4", pops + 3);
    cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t4_wr_held", 32'(wr_s), 32'd0);
      chk("t4_tx_held", 32'(tx_s), 32'hFF);
      chk("t4_busy", 32'(busy_s), 32'd1);
    end
    force_full = 1'b0;
    wait_push("t4");
    repeat (5) cycle();
    chk("t4_one_push", 32'(pushes), 32'(p + 1));

    // Reset mid-frame discards a partial frame
    rx_q.push_back(8'h11);
    wait_pops("t5", pops + 1);
    cycle();
    rst_req = 1'b1; cycle(); rst_req = 1'b0; pos = 0;
    cycle();
    chk("t5_a_zeroed", 32'(a_s), 32'd0);
    chk("t5_busy", 32'(busy_s), 32'd0);
    frame(8'h02, 8'h02, 8'h20);
    wait_push("t5");
    chk("t5_tx", 32'(txlog[txlog.size()-1]), 32'h04);

    // Reset in the push cycle: the push still happens
    force_full = 1'b1;
    frame(8'h10, 8'h20, 8'h20);
    wait_pops("trw", pops + 3);
    cycle(); cycle();
    force_full = 1'b0; rst_req = 1'b1;
    cycle();
    chk("trw_push", 32'(wr_s), 32'd1);
    chk("trw_tx", 32'(tx_s), 32'h30);
    rst_req = 1'b0; pos = 0;
    cycle();
    chk("trw_busy", 32'(busy_s), 32'd0);
    chk("trw_tx_zero", 32'(tx_s), 32'd0);
    chk("trw_wr_once", 32'(wr_s), 32'd0);

    // Inter-byte gap
    rx_q.push_back(8'h01);
    wait_pops("t6", pops + 1);
    q = fe_cnt;
    repeat (20) cycle();
`ifdef INTF_TIMEOUT_EN
    chk("t6_ferr_count", 32'(fe_cnt), 32'(q + 1));
    chk("t6_ferr_cycle", 32'(fe_cyc - a_pop_cyc), 32'd16);
    chk("t6_a_kept", 32'(a_s), 32'h01);
    chk("t6_busy", 32'(busy_s), 32'd0);
    pos = 0;
    frame(8'h07, 8'h01, 8'h20);
`else
    chk("t6_no_ferr", 32'(fe_cnt), 32'(q));
    chk("t6_busy_wait", 32'(busy_s), 32'd1);
    rx_q.push_back(8'h07); rx_q.push_back(8'h20);
    exp_q.push_back(alu_f(8'h01, 8'h07, 6'h20));
`endif
    wait_push("t6");
    chk("t6_tx", 32'(txlog[txlog.size()-1]), 32'h08);

    // Back-to-back throughput
    p = wr_cycs.size();
    for (int i = 0; i < 3; i++) frame(8'($urandom), 8'($urandom), 8'h20);
    q = 0;
    while (pushes < p + 3 && q < 100) begin cycle(); q++; end
    chk("tput_pushes", 32'(wr_cycs.size()), 32'(p + 3));
    if (wr_cycs.size() == p + 3) begin
      chk("tput_gap1", 32'(wr_cycs[p+1] - wr_cycs[p]), 32'd5);
      chk("tput_gap2", 32'(wr_cycs[p+2] - wr_cycs[p+1]), 32'd5);
    end

    // Random frames with RX gaps and TX backpressure
    rand_bp = 1'b1; rand_gap = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ob = 8'($urandom);
      ob[5:0] = ops[$urandom_range(0, 6)];
      frame(8'($urandom), 8'($urandom), ob);
    end
    q = 0;
    while ((txlog.size() < exp_q.size() || rx_q.size() > 0) && q < 3000) begin cycle(); q++; end
    rand_bp = 1'b0; rand_gap = 1'b0;
    repeat (6) cycle();
    chk("rand_count", 32'(txlog.size()), 32'(exp_q.size()));
    chk("rand_rx_drained", 32'(rx_q.size()), 32'd0);
    for (int i = 0; i < txlog.size() && i < exp_q.size(); i++)
      chk("rand_stream", 32'(txlog[i]), 32'(exp_q[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
